// File: rtl/zbuf_fetch_pkg.sv
// Shared render definitions for the Z-buffer fetch stage: field widths,
// FSM state codes, Z_COMPARE encodings and the depth-read decision.
package zbuf_fetch_pkg;

    localparam int COORD_W = 10;
    localparam int Z_W     = 16;
    localparam int ADDR_W  = 24;

    // Fetch FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // RENDER_MODE Z_COMPARE encodings
    localparam logic [2:0] ZC_LESS   = 3'b001;
    localparam logic [2:0] ZC_ALWAYS = 3'b110;
    localparam logic [2:0] ZC_NEVER  = 3'b111;

    // Depth value reported when no Z-buffer read was made
    localparam logic [Z_W-1:0] ZBUF_CLEAR = 16'hFFFF;

    // A stored depth is only needed when the test is enabled and its outcome
    // actually depends on the stored value.
    function automatic logic zread_needed(input logic en, input logic [2:0] cmp);
        return en && (cmp != ZC_ALWAYS) && (cmp != ZC_NEVER);
    endfunction

endpackage

// File: rtl/zbuf_fetch_if.sv
// Bus bundle for zbuf_fetch: fragment input, depth-test config, SRAM read
// port and the output handshake toward the early Z-test stage.
interface zbuf_fetch_if
    import zbuf_fetch_pkg::*;
#(
    parameter int DATA_W = 64
);

    logic                frag_valid;
    logic                frag_ready;
    logic [COORD_W-1:0]  frag_x;
    logic [COORD_W-1:0]  frag_y;
    logic [Z_W-1:0]      frag_z;
    logic [DATA_W-1:0]   frag_data;

    logic                z_test_en;
    logic [2:0]          z_compare;
    logic [ADDR_W-1:0]   z_base;
    logic [3:0]          fb_width_log2;

    logic                sram_req;
    logic                sram_ack;
    logic [ADDR_W-1:0]   sram_addr;
    logic                sram_rdata_valid;
    logic [Z_W-1:0]      sram_rdata;

    logic                out_valid;
    logic                out_ready;
    logic [COORD_W-1:0]  out_x;
    logic [COORD_W-1:0]  out_y;
    logic [Z_W-1:0]      out_z;
    logic [Z_W-1:0]      out_zbuf;
    logic [DATA_W-1:0]   out_data;

    // Fetch block side
    modport master (
        input  frag_valid, frag_x, frag_y, frag_z, frag_data,
        input  z_test_en, z_compare, z_base, fb_width_log2,
        input  sram_ack, sram_rdata_valid, sram_rdata,
        input  out_ready,
        output frag_ready, sram_req, sram_addr,
        output out_valid, out_x, out_y, out_z, out_zbuf, out_data
    );

    // Surrounding pipeline / memory side
    modport slave (
        output frag_valid, frag_x, frag_y, frag_z, frag_data,
        output z_test_en, z_compare, z_base, fb_width_log2,
        output sram_ack, sram_rdata_valid, sram_rdata,
        output out_ready,
        input  frag_ready, sram_req, sram_addr,
        input  out_valid, out_x, out_y, out_z, out_zbuf, out_data
    );

endinterface

// File: rtl/zbuf_fetch.sv
// Z-buffer fetch: accepts one fragment at a time, reads the stored depth at
// its screen position when the depth test needs it, and presents the fragment
// together with that depth to the early Z-test stage.
module zbuf_fetch
    import zbuf_fetch_pkg::*;
#(
    parameter int DATA_W = 64
)
(
    input  logic          clk,
    input  logic          rst_n,
    zbuf_fetch_if.master  bus
);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [COORD_W-1:0]  x_q;
    logic [COORD_W-1:0]  y_q;
    logic [Z_W-1:0]      z_q;
    logic [Z_W-1:0]      zbuf_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_calc;
    logic                accept;
    logic                rd_needed;
    logic                rd_done;

    // The depth-test config is sampled only at accept; its effect is carried
    // forward by the state choice, so later config changes cannot leak in.
    assign accept    = bus.frag_valid && (state_q == ST_IDLE);
    assign rd_needed = zread_needed(bus.z_test_en, bus.z_compare);

    // Row-major word address, wrapping naturally at 24 bits
    assign addr_calc = bus.z_base
                     + (ADDR_W'(bus.frag_y) << bus.fb_width_log2)
                     + ADDR_W'(bus.frag_x);

    // Return data counts in WAIT, or in REQ when it arrives with the ack
    assign rd_done = bus.sram_rdata_valid &&
                     ((state_q == ST_WAIT) || ((state_q == ST_REQ) && bus.sram_ack));

    // Next-state selection for the single in-flight fragment
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)        state_d = rd_needed ? ST_REQ : ST_OUT;
            ST_REQ:  if (bus.sram_ack)  state_d = bus.sram_rdata_valid ? ST_OUT : ST_WAIT;
            ST_WAIT: if (bus.sram_rdata_valid) state_d = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fragment capture at accept and stored-depth capture on read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            data_q <= '0;
            addr_q <= '0;
            zbuf_q <= ZBUF_CLEAR;
        end else begin
            if (accept) begin
                x_q    <= bus.frag_x;
                y_q    <= bus.frag_y;
                z_q    <= bus.frag_z;
                data_q <= bus.frag_data;
                if (rd_needed) begin
                    addr_q <= addr_calc;
                end else begin
                    zbuf_q <= ZBUF_CLEAR;
                end
            end
            if (rd_done) begin
                zbuf_q <= bus.sram_rdata;
            end
        end
    end

    // Handshake outputs decode from state only
    assign bus.frag_ready = (state_q == ST_IDLE);
    assign bus.sram_req   = (state_q == ST_REQ);
    assign bus.out_valid  = (state_q == ST_OUT);

    assign bus.sram_addr  = addr_q;
    assign bus.out_x      = x_q;
    assign bus.out_y      = y_q;
    assign bus.out_z      = z_q;
    assign bus.out_zbuf   = zbuf_q;
    assign bus.out_data   = data_q;

endmodule
